// File: rtl/ex_muldiv_unit_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// op-codes, FSM states and op-decode helpers.
package ex_muldiv_unit_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit request and result bundle.
interface ex_muldiv_unit_if;
   import ex_muldiv_unit_pkg::*;

   logic              EX_MD_start;
   logic [2:0]        EX_MD_op;
   logic [DATA_W-1:0] EX_DataBusA;
   logic [DATA_W-1:0] EX_DataBusB;
   logic              MD_flush;
   logic              MD_busy;
   logic              MD_done;
   logic              MD_divZero;
   logic [DATA_W-1:0] HI;
   logic [DATA_W-1:0] LO;

   modport master (
      output EX_MD_start, EX_MD_op, EX_DataBusA, EX_DataBusB, MD_flush,
      input  MD_busy, MD_done, MD_divZero, HI, LO
   );

   modport slave (
      input  EX_MD_start, EX_MD_op, EX_DataBusA, EX_DataBusB, MD_flush,
      output MD_busy, MD_done, MD_divZero, HI, LO
   );

endinterface

// File: rtl/ex_muldiv_unit_md_negate32.sv
// Conditional two's-complement of a 32-bit word; inc is the carry-in so two
// instances can be chained into a 64-bit negation.
module md_negate32 (
   input  logic        neg,
   input  logic        inc,
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = neg ? (~a + {31'd0, inc}) : a;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle radix-2
// shift-add multiply and restoring divide on magnitudes, sign fix-up in FIX.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
(
   input logic           sysclk,
   input logic           reset,
   ex_muldiv_unit_if.slave md
);

   md_state_e             state, state_nx;
   logic [4:0]            cnt;
   logic [2*DATA_W-1:0]   acc;
   logic [DATA_W-1:0]     opnd;
   logic                  is_div_r, sign_a_r, sign_b_r, div_zero_r;
   logic [DATA_W-1:0]     hi_r, lo_r;

   logic                  op_arith, op_signed, op_div, b_zero;
   logic [DATA_W-1:0]     mag_a, mag_b;
   logic                  ld_arith, wr_hi_mt, wr_lo_mt, fix_commit;
   logic [DATA_W:0]       mul_sum, div_rem, div_diff;
   logic [2*DATA_W-1:0]   mul_next, div_next;
   logic                  sign_diff, neg_hi, inc_hi;
   logic [DATA_W-1:0]     res_lo, res_hi;

   assign op_arith  = op_is_arith(md.EX_MD_op);
   assign op_signed = op_is_signed(md.EX_MD_op);
   assign op_div    = op_is_div(md.EX_MD_op);
   assign b_zero    = (md.EX_DataBusB == '0);

   md_negate32 u_mag_a (.neg(op_signed & md.EX_DataBusA[DATA_W-1]), .inc(1'b1),
                        .a(md.EX_DataBusA), .y(mag_a));
   md_negate32 u_mag_b (.neg(op_signed & md.EX_DataBusB[DATA_W-1]), .inc(1'b1),
                        .a(md.EX_DataBusB), .y(mag_b));

   // One iteration: multiply adds the multiplicand when the multiplier LSB is
   // set and shifts right; divide shifts left and subtracts when it fits.
   assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[DATA_W-1:1]};
   assign div_rem  = acc[2*DATA_W-1:DATA_W-1];
   assign div_diff = div_rem - {1'b0, opnd};
   assign div_next = div_diff[DATA_W] ? {div_rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

   // Multiply negates the full 64-bit product; divide negates the quotient on
   // differing signs and gives the remainder the dividend's sign.
   assign sign_diff = sign_a_r ^ sign_b_r;
   assign neg_hi    = is_div_r ? sign_a_r : sign_diff;
   assign inc_hi    = is_div_r ? 1'b1 : (acc[DATA_W-1:0] == '0);

   md_negate32 u_res_lo (.neg(sign_diff), .inc(1'b1), .a(acc[DATA_W-1:0]), .y(res_lo));
   md_negate32 u_res_hi (.neg(neg_hi), .inc(inc_hi), .a(acc[2*DATA_W-1:DATA_W]), .y(res_hi));

   always_comb begin
      state_nx   = state;
      ld_arith   = 1'b0;
      wr_hi_mt   = 1'b0;
      wr_lo_mt   = 1'b0;
      fix_commit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (md.EX_MD_start && !md.MD_flush) begin
               if (op_arith) begin
                  ld_arith = 1'b1;
                  state_nx = (op_div && b_zero) ? ST_FIX : ST_CALC;
               end else begin
                  wr_hi_mt = (md.EX_MD_op == OP_MTHI);
                  wr_lo_mt = (md.EX_MD_op == OP_MTLO);
               end
            end
         end
         ST_CALC: begin
            if (md.MD_flush)
               state_nx = ST_IDLE;
            else if (cnt == 5'd31)
               state_nx = ST_FIX;
         end
         ST_FIX: begin
            state_nx   = ST_IDLE;
            fix_commit = !md.MD_flush && !div_zero_r;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         div_zero_r <= 1'b0;
         hi_r       <= '0;
         lo_r       <= '0;
      end else begin
         state <= state_nx;
         if (ld_arith) begin
            cnt        <= '0;
            div_zero_r <= op_div && b_zero;
         end else if (state == ST_CALC) begin
            cnt <= cnt + 5'd1;
         end
         if (wr_hi_mt) hi_r <= md.EX_DataBusA;
         if (wr_lo_mt) lo_r <= md.EX_DataBusA;
         if (fix_commit) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
         end
      end
   end

   // Datapath registers carry no reset; control decides when they matter.
   always_ff @(posedge sysclk) begin
      if (ld_arith) begin
         acc      <= {{DATA_W{1'b0}}, (op_div ? mag_a : mag_b)};
         opnd     <= op_div ? mag_b : mag_a;
         is_div_r <= op_div;
         sign_a_r <= op_signed & md.EX_DataBusA[DATA_W-1];
         sign_b_r <= op_signed & md.EX_DataBusB[DATA_W-1];
      end else if (state == ST_CALC) begin
         acc <= is_div_r ? div_next : mul_next;
      end
   end

   assign md.MD_busy    = (state != ST_IDLE);
   assign md.MD_done    = (state == ST_FIX) && !md.MD_flush && !reset;
   assign md.MD_divZero = md.MD_done && div_zero_r;
   assign md.HI         = hi_r;
   assign md.LO         = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed HI/LO results.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic sysclk;
   logic reset;
   int   checks;
   int   errors;
   int   cyc;

   ex_muldiv_unit_if md_if();

   ex_muldiv_unit dut (
      .sysclk (sysclk),
      .reset  (reset),
      .md     (md_if)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Presents a start in cycle 0; returns in cycle 1.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_if.EX_MD_op    = op;
      md_if.EX_DataBusA = a;
      md_if.EX_DataBusB = b;
      md_if.EX_MD_start = 1'b1;
      tick();
      md_if.EX_MD_start = 1'b0;
   endtask

   // Called in cycle 1; returns in the cycle where MD_done is seen (bounded).
   task automatic wait_done(output int n);
      n = 1;
      while (!md_if.MD_done && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic run_full(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
      int n;
      start_op(op, a, b);
      chk({tag, "_busy1"}, md_if.MD_busy, 1);
      wait_done(n);
      chk({tag, "_done_cyc"}, n, 33);
      chk({tag, "_divzero"}, md_if.MD_divZero, 0);
      tick();
      chk({tag, "_busy34"}, md_if.MD_busy, 0);
      chk({tag, "_hi"}, md_if.HI, exp_hi);
      chk({tag, "_lo"}, md_if.LO, exp_lo);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      md_if.EX_MD_start = 1'b0;
      md_if.EX_MD_op    = OP_MULT;
      md_if.EX_DataBusA = '0;
      md_if.EX_DataBusB = '0;
      md_if.MD_flush    = 1'b0;
      tick(); tick(); tick();
      chk("rst_hi", md_if.HI, 0);
      chk("rst_lo", md_if.LO, 0);
      chk("rst_busy", md_if.MD_busy, 0);
      chk("rst_done", md_if.MD_done, 0);
      chk("rst_divzero", md_if.MD_divZero, 0);
      reset = 1'b0;
      tick();

      run_full("mult_neg", OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_full("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_full("mult_negneg", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F);
      run_full("div_neg", OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_full("div_ovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // Divide by zero completes in cycle 1 and leaves HI/LO alone.
      start_op(OP_DIVU, 32'd7, 32'd0);
      wait_done(cyc);
      chk("divz_cyc", cyc, 1);
      chk("divz_flag", md_if.MD_divZero, 1);
      tick();
      chk("divz_busy", md_if.MD_busy, 0);
      chk("divz_flag_low", md_if.MD_divZero, 0);
      chk("divz_hi", md_if.HI, 32'h00000000);
      chk("divz_lo", md_if.LO, 32'h80000000);

      // A second start while busy must not disturb the first operation.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (4) tick();
      start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(cyc);
      chk("ign_done_cyc", cyc + 5, 33);
      tick();
      chk("ign_hi", md_if.HI, 32'd2);
      chk("ign_lo", md_if.LO, 32'd14);

      // Flush in FIX suppresses done and the HI/LO write.
      start_op(OP_MULT, 32'd5, 32'd6);
      wait_done(cyc);
      chk("fixflush_cyc", cyc, 33);
      md_if.MD_flush = 1'b1;
      #1;
      chk("fixflush_done", md_if.MD_done, 0);
      tick();
      md_if.MD_flush = 1'b0;
      chk("fixflush_busy", md_if.MD_busy, 0);
      chk("fixflush_hi", md_if.HI, 32'd2);
      chk("fixflush_lo", md_if.LO, 32'd14);

      // MTLO/MTHI write immediately without busy or done.
      start_op(OP_MTLO, 32'hCAFEF00D, 32'd0);
      start_op(OP_MTHI, 32'h12345678, 32'd0);
      chk("mthi_busy", md_if.MD_busy, 0);
      chk("mthi_done", md_if.MD_done, 0);
      chk("mthi_hi", md_if.HI, 32'h12345678);
      chk("mtlo_lo", md_if.LO, 32'hCAFEF00D);

      // Flush at cycle 10 of a multiply.
      start_op(OP_MULT, 32'd3, 32'd4);
      repeat (9) tick();
      md_if.MD_flush = 1'b1;
      chk("flush_busy10", md_if.MD_busy, 1);
      tick();
      md_if.MD_flush = 1'b0;
      chk("flush_busy11", md_if.MD_busy, 0);
      cyc = 0;
      repeat (30) begin
         if (md_if.MD_done) cyc++;
         tick();
      end
      chk("flush_no_done", cyc, 0);
      chk("flush_hi", md_if.HI, 32'h12345678);
      chk("flush_lo", md_if.LO, 32'hCAFEF00D);

      // Flush in IDLE drops a simultaneous start.
      md_if.MD_flush = 1'b1;
      start_op(OP_MTHI, 32'h0000DEAD, 32'd0);
      chk("idleflush_hi", md_if.HI, 32'h12345678);
      start_op(OP_MULT, 32'd3, 32'd4);
      md_if.MD_flush = 1'b0;
      chk("idleflush_busy", md_if.MD_busy, 0);

      // Reset at cycle 20 of a divide.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_busy", md_if.MD_busy, 0);
      chk("midrst_hi", md_if.HI, 0);
      chk("midrst_lo", md_if.LO, 0);
      cyc = 0;
      repeat (20) begin
         if (md_if.MD_done) cyc++;
         tick();
      end
      chk("midrst_no_done", cyc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state changes occur on the rising edge of sysclk.
REQ-002 SHALL have ports: sysclk  in  1  clock.
REQ-003 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: EX_MD_start  in  1  request from EX stage, single-cycle qualifier.
REQ-005 SHALL have ports: EX_MD_op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have ports: EX_DataBusA  in  32  forwarded rs operand.
REQ-007 SHALL have ports: EX_DataBusB  in  32  forwarded rt operand.
REQ-008 SHALL have ports: MD_flush  in  1  abort in-flight operation (exception/IRQ squash).
REQ-009 SHALL have ports: MD_busy  out  1  stall request to hazard logic.
REQ-010 SHALL have ports: MD_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: MD_divZero  out  1  divide-by-zero flag, valid with MD_done.
REQ-012 SHALL have ports: HI, LO  out  32 each  architectural HI/LO registers, feeding EX/MEM for MFHI/MFLO.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; MD_busy = 1 in CALC and FIX, 0 in IDLE.
REQ-014 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch operand magnitudes (signed ops) or raw values (unsigned), operand signs, and op, clear the 5-bit iteration counter, and go to CALC.
REQ-015 CALC SHALL perform one iteration per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide; exactly 32 cycles, then FIX.
REQ-016 FIX SHALL last one cycle: MD_done = 1, sign correction applied, HI/LO written at the end of FIX, next state IDLE.
REQ-017 Timing: start high in cycle 0 -> MD_busy high in cycles 1..33, MD_done high in cycle 33, new HI/LO visible from cycle 34.
REQ-018 Multiply: {HI,LO} = 64-bit product; signed product negated when the operand signs differ.
REQ-019 Divide: LO = quotient, HI = remainder; quotient negative iff the signs differ; remainder takes the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-021 Divisor == 0 SHALL skip CALC: IDLE -> FIX directly, MD_done and MD_divZero high in cycle 1, HI/LO unchanged.
REQ-022 MTHI/MTLO with start in IDLE SHALL write HI or LO from EX_DataBusA at that edge; no busy, no done.
REQ-023 Start while MD_busy = 1 SHALL be ignored (upstream stalls; the request is re-presented after completion).
REQ-024 MD_flush in CALC or FIX SHALL return to IDLE next edge with HI/LO unchanged and no MD_done; flush outranks FIX completion; flush in IDLE also drops a simultaneous start.
REQ-025 MD_divZero SHALL be 0 whenever MD_done = 0.

Reset
REQ-026 Reset SHALL force IDLE and set HI = LO = 0, MD_busy = MD_done = MD_divZero = 0, counter = 0; reset mid-operation discards the result.
REQ-027 Reset SHALL take priority over start and flush in the same cycle.

Structure
REQ-028 Op-code and state encodings SHALL reside in the shared pipeline definitions include used by the control unit and hazard logic.
REQ-029 A single sub-module, md_negate32 (conditional two's-complement), SHALL be instantiated for operand magnitude and result sign correction; the rest is flat.
REQ-030 The datapath SHALL be one 64-bit accumulator/remainder register plus one 32-bit operand register; no combinational 32x32 multiplier.

Verification
REQ-031 MULT 0xFFFFFFFE x 0x00000003 -> done in cycle 33, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7/0 -> done + divZero in cycle 1, HI/LO unchanged.
REQ-034 MTHI 0x12345678, then MULT started, flush at cycle 10 -> busy drops at cycle 11, no done, HI = 0x12345678.
REQ-035 Reset asserted at cycle 20 of a DIV -> IDLE, HI = LO = 0; a second start during busy is ignored and the first result completes unaltered.
